// File: rtl/register_file_multiport.sv
// Multiport register file with two write ports, a per-register busy scoreboard
// and an optional same-cycle write-to-read bypass for the pipelined core.
module register_file_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic [1:0]                       wr_en,
    input  logic [2*ADDR_WIDTH-1:0]          wr_address,
    input  logic [2*DATA_WIDTH-1:0]          wr_data,
    input  logic                             reserve,
    input  logic [ADDR_WIDTH-1:0]            reserve_address
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam bit BYP_EN  = (BYPASS != 0);
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy_reg;
    logic [DEPTH-1:0]      r_busy_next;

    logic [ADDR_WIDTH-1:0] w_wr_addr [2];
    logic [DATA_WIDTH-1:0] w_wr_data [2];
    logic [1:0]            w_wr_en;
    logic                  w_reserve;

    // Writes and reserves aimed at a hardwired zero register are dropped here,
    // so neither storage nor the bypass path ever sees them.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr_port
            assign w_wr_addr[gi] = wr_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wr_data[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_wr_en[gi]   = wr_en[gi] && !(ZERO_EN && (w_wr_addr[gi] == '0));
        end
    endgenerate

    assign w_reserve = reserve && !(ZERO_EN && (reserve_address == '0));

    // Busy update order: write clears first, reserve applied last so it wins.
    always_comb begin
        r_busy_next = r_busy_reg;
        if (w_wr_en[0]) begin
            r_busy_next[w_wr_addr[0]] = 1'b0;
        end
        if (w_wr_en[1]) begin
            r_busy_next[w_wr_addr[1]] = 1'b0;
        end
        if (w_reserve) begin
            r_busy_next[reserve_address] = 1'b1;
        end
    end

    // Port 1 is assigned after port 0 so it wins an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy_reg <= '0;
        end else begin
            if (w_wr_en[0]) begin
                r_mem[w_wr_addr[0]] <= w_wr_data[0];
            end
            if (w_wr_en[1]) begin
                r_mem[w_wr_addr[1]] <= w_wr_data[1];
            end
            r_busy_reg <= r_busy_next;
        end
    end

    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd_port
            logic [ADDR_WIDTH-1:0] w_ra;
            logic                  w_hit0;
            logic                  w_hit1;
            logic                  w_rsv_hit;
            logic                  w_zero;

            assign w_ra      = rd_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_hit1    = BYP_EN && w_wr_en[1] && (w_wr_addr[1] == w_ra);
            assign w_hit0    = BYP_EN && w_wr_en[0] && (w_wr_addr[0] == w_ra);
            assign w_rsv_hit = w_reserve && (reserve_address == w_ra);
            assign w_zero    = ZERO_EN && (w_ra == '0);

            // A bypassed write has already cleared busy unless a reserve re-arms it.
            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                w_zero ? '0 :
                w_hit1 ? w_wr_data[1] :
                w_hit0 ? w_wr_data[0] :
                         r_mem[w_ra];
            assign rd_busy[gi] =
                w_zero              ? 1'b0 :
                (w_hit1 || w_hit0)  ? w_rsv_hit :
                                      r_busy_reg[w_ra];
        end
    endgenerate

endmodule

// File: tb/tb_register_file_multiport.sv
// Directed bench: a bypassing and a non-bypassing 32x32 instance share stimulus,
// plus a 16-bit, 8-entry, 4-read-port instance.
module tb_register_file_multiport;

    logic clk;
    logic reset;

    logic [9:0]  rd_address;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_address;
    logic [63:0] wr_data;
    logic        reserve;
    logic [4:0]  reserve_address;

    logic [11:0] c_rd_address;
    logic [63:0] c_rd_data;
    logic [3:0]  c_rd_busy;
    logic [1:0]  c_wr_en;
    logic [5:0]  c_wr_address;
    logic [31:0] c_wr_data;
    logic        c_reserve;
    logic [2:0]  c_reserve_address;

    int n_tests;
    int n_fail;

    register_file_multiport #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .BYPASS(1), .ZERO_REG(1)
    ) u_dut_byp (
        .clk(clk), .reset(reset),
        .rd_address(rd_address), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .reserve(reserve), .reserve_address(reserve_address)
    );

    register_file_multiport #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .BYPASS(0), .ZERO_REG(1)
    ) u_dut_nobyp (
        .clk(clk), .reset(reset),
        .rd_address(rd_address), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .reserve(reserve), .reserve_address(reserve_address)
    );

    register_file_multiport #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(4), .BYPASS(1), .ZERO_REG(1)
    ) u_dut_small (
        .clk(clk), .reset(reset),
        .rd_address(c_rd_address), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_address(c_wr_address), .wr_data(c_wr_data),
        .reserve(c_reserve), .reserve_address(c_reserve_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        rd_address = '0; wr_en = '0; wr_address = '0; wr_data = '0;
        reserve = 1'b0; reserve_address = '0;
        c_rd_address = '0; c_wr_en = '0; c_wr_address = '0; c_wr_data = '0;
        c_reserve = 1'b0; c_reserve_address = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        rd_address = {5'd31, 5'd1};
        #1;
        check("init_data_byp", a_rd_data, 64'h0);
        check("init_busy_byp", {62'h0, a_rd_busy}, 64'h0);

        // Fill r1..r31 with nonzero values through write port 0
        for (int i = 1; i < 32; i++) begin
            wr_en      = 2'b01;
            wr_address = {5'd0, 5'(i)};
            wr_data    = {32'h0, 32'h1000_0000 | 32'(i)};
            tick();
        end
        wr_en = 2'b00;
        rd_address = {5'd1, 5'd31};
        #1;
        check("fill_byp", a_rd_data, {32'h1000_0001, 32'h1000_001F});
        check("fill_nobyp", b_rd_data, {32'h1000_0001, 32'h1000_001F});
        tick();

        // Reset wins over a dual write to r5 and a reserve of r6
        reset = 1'b1;
        wr_en = 2'b11;
        wr_address = {5'd5, 5'd5};
        wr_data = {32'h5A5A_5A5A, 32'hA5A5_A5A5};
        reserve = 1'b1;
        reserve_address = 5'd6;
        tick();
        reset = 1'b0; wr_en = 2'b00; reserve = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_address = {5'(31 - i), 5'(i)};
            #1;
            check($sformatf("rst_data_byp_r%0d", i), a_rd_data, 64'h0);
            check($sformatf("rst_busy_byp_r%0d", i), {62'h0, a_rd_busy}, 64'h0);
            check($sformatf("rst_data_nobyp_r%0d", i), b_rd_data, 64'h0);
            tick();
        end

        // Dual-write collision on r7: port 1 wins
        wr_en = 2'b11;
        wr_address = {5'd7, 5'd7};
        wr_data = {32'h5555_1111, 32'hAAAA_0000};
        rd_address = {5'd7, 5'd7};
        #1;
        check("coll_bypass_byp", a_rd_data, {32'h5555_1111, 32'h5555_1111});
        check("coll_bypass_nobyp", b_rd_data, 64'h0);
        tick();
        wr_en = 2'b00;
        #1;
        check("coll_stored_byp", a_rd_data, {32'h5555_1111, 32'h5555_1111});
        check("coll_stored_nobyp", b_rd_data, {32'h5555_1111, 32'h5555_1111});
        tick();

        // Bypass on/off via write port 0, r3 holds 0 after reset
        wr_en = 2'b01;
        wr_address = {5'd0, 5'd3};
        wr_data = {32'h0, 32'hDEAD_BEEF};
        rd_address = {5'd7, 5'd3};
        #1;
        check("byp_same_cycle", a_rd_data, {32'h5555_1111, 32'hDEAD_BEEF});
        check("nobyp_same_cycle", b_rd_data, {32'h5555_1111, 32'h0000_0000});
        tick();
        wr_en = 2'b00;
        #1;
        check("byp_next_cycle", a_rd_data, {32'h5555_1111, 32'hDEAD_BEEF});
        check("nobyp_next_cycle", b_rd_data, {32'h5555_1111, 32'hDEAD_BEEF});
        tick();

        // Independent writes to different addresses, each bypassed to its own port
        wr_en = 2'b11;
        wr_address = {5'd11, 5'd10};
        wr_data = {32'h0000_0011, 32'h0000_0010};
        rd_address = {5'd10, 5'd11};
        #1;
        check("split_bypass_byp", a_rd_data, {32'h0000_0010, 32'h0000_0011});
        check("split_bypass_nobyp", b_rd_data, 64'h0);
        tick();
        wr_en = 2'b00;

        // Scoreboard: reserve r9, busy appears from the next cycle only
        reserve = 1'b1;
        reserve_address = 5'd9;
        rd_address = {5'd9, 5'd9};
        #1;
        check("rsv_same_cycle_byp", {62'h0, a_rd_busy}, 64'h0);
        check("rsv_same_cycle_nobyp", {62'h0, b_rd_busy}, 64'h0);
        tick();
        reserve = 1'b0;
        #1;
        check("rsv_next_byp", {62'h0, a_rd_busy}, 64'h3);
        check("rsv_next_nobyp", {62'h0, b_rd_busy}, 64'h3);
        tick();
        check("rsv_hold_byp", {62'h0, a_rd_busy}, 64'h3);

        // Retire r9=42 on write port 1
        wr_en = 2'b10;
        wr_address = {5'd9, 5'd0};
        wr_data = {32'd42, 32'h0};
        #1;
        check("clr_same_busy_byp", {62'h0, a_rd_busy}, 64'h0);
        check("clr_same_data_byp", a_rd_data, {32'd42, 32'd42});
        check("clr_same_busy_nobyp", {62'h0, b_rd_busy}, 64'h3);
        check("clr_same_data_nobyp", b_rd_data, 64'h0);
        tick();
        wr_en = 2'b00;
        #1;
        check("clr_next_busy_nobyp", {62'h0, b_rd_busy}, 64'h0);
        check("clr_next_data_nobyp", b_rd_data, {32'd42, 32'd42});
        tick();

        // Reserve and write r9 together: reserve wins, data still lands
        wr_en = 2'b01;
        wr_address = {5'd0, 5'd9};
        wr_data = {32'h0, 32'd77};
        reserve = 1'b1;
        reserve_address = 5'd9;
        #1;
        check("rsvwr_same_busy_byp", {62'h0, a_rd_busy}, 64'h3);
        check("rsvwr_same_data_byp", a_rd_data, {32'd77, 32'd77});
        check("rsvwr_same_busy_nobyp", {62'h0, b_rd_busy}, 64'h0);
        tick();
        wr_en = 2'b00; reserve = 1'b0;
        #1;
        check("rsvwr_next_busy_byp", {62'h0, a_rd_busy}, 64'h3);
        check("rsvwr_next_data_nobyp", b_rd_data, {32'd77, 32'd77});
        check("rsvwr_next_busy_nobyp", {62'h0, b_rd_busy}, 64'h3);
        tick();

        // Zero register: writes and reserve to r0 ignored, including bypass
        wr_en = 2'b11;
        wr_address = {5'd0, 5'd0};
        wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        reserve = 1'b1;
        reserve_address = 5'd0;
        rd_address = {5'd0, 5'd0};
        #1;
        check("r0_bypass_data", a_rd_data, 64'h0);
        check("r0_bypass_busy", {62'h0, a_rd_busy}, 64'h0);
        tick();
        wr_en = 2'b00; reserve = 1'b0;
        #1;
        check("r0_next_data_byp", a_rd_data, 64'h0);
        check("r0_next_busy_byp", {62'h0, a_rd_busy}, 64'h0);
        check("r0_next_data_nobyp", b_rd_data, 64'h0);
        check("r0_next_busy_nobyp", {62'h0, b_rd_busy}, 64'h0);
        tick();

        // Small instance: r1..r7 = index*0x111
        for (int i = 1; i < 8; i++) begin
            c_wr_en = 2'b01;
            c_wr_address = {3'd0, 3'(i)};
            c_wr_data = {16'h0, 16'(i * 16'h111)};
            tick();
        end
        c_wr_en = 2'b00;
        c_rd_address = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        check("small_odd", c_rd_data, {16'h0777, 16'h0555, 16'h0333, 16'h0111});
        c_rd_address = {3'd0, 3'd6, 3'd4, 3'd2};
        #1;
        check("small_even_r0", c_rd_data, {16'h0000, 16'h0666, 16'h0444, 16'h0222});
        tick();

        c_reserve = 1'b1;
        c_reserve_address = 3'd7;
        c_rd_address = {3'd7, 3'd0, 3'd6, 3'd7};
        tick();
        c_reserve = 1'b0;
        #1;
        check("small_busy_r7", {60'h0, c_rd_busy}, 64'h9);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_multiport.md
# register_file_multiport

Parametrised register file for the pipelined core: configurable data width, register count and read-port count, two independent write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection. It sits between the decode stage, which reads operands and reserves destinations, and the execute and memory-writeback stages, which retire results through the two write ports.

## Interface
- DATA_WIDTH, 32: bits per register.
- ADDR_WIDTH, 5: register address width; depth = 2**ADDR_WIDTH.
- READ_PORTS, 2: number of read ports (1..4).
- BYPASS, 1: 1 = forward same-cycle write data and busy clears to read ports; 0 = reads return stored state only.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero and never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- rd_address  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data, same packing.
- rd_busy  out  READ_PORTS  1 = the addressed register has an outstanding reservation.
- wr_en  in  2  per-write-port enable (port 0 = ALU, port 1 = load/writeback).
- wr_address  in  2*ADDR_WIDTH  packed write addresses.
- wr_data  in  2*DATA_WIDTH  packed write data.
- reserve  in  1  marks reserve_address busy at the next edge.
- reserve_address  in  ADDR_WIDTH  destination register being reserved.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH data array plus a busy bit per register.
- Write: on the edge, if wr_en[p], reg[wr_address[p]] <= wr_data[p] and busy[wr_address[p]] <= 0.
- Both write ports enabled to the same address: port 1 wins, for both data and bypass.
- Reserve: on the edge, if reserve, busy[reserve_address] <= 1. Reserve and write to the same address in the same cycle: reserve wins, so busy = 1 and the data is still written.
- ZERO_REG=1: writes and reserves to address 0 are ignored; rd_data = 0 and rd_busy = 0 for address 0, including via the bypass path.
- Read (combinational, per port k):
  - BYPASS=1 and a matching enabled write exists (port 1 checked first, then port 0): rd_data = that wr_data; rd_busy = 1 only if reserve targets the same address this cycle, else 0.
  - Otherwise: rd_data = stored value; rd_busy = stored busy bit.
- Reset: all registers = 0 and all busy bits = 0 at the edge. Reset has priority over writes and reserves in the same cycle.
- Reset values of outputs: after the reset edge, rd_data = 0 and rd_busy = 0 for every address, unless bypass is active that cycle.

## Timing
- Write latency: 1 edge. With BYPASS=0, data is visible from the cycle after wr_en. With BYPASS=1, it is visible combinationally in the same cycle.
- Busy set: visible from the cycle after reserve. It is not bypassed, except when it overrides a same-cycle write clear as stated above.
- Busy clear: visible from the cycle after the write, or in the same cycle with BYPASS=1.
- No handshake; every port is sampled on every edge. Address aliasing across read ports is legal, and all read ports are independent.
- Reset mid-operation: a pending write or reserve in the reset cycle is dropped; the next cycle sees all zeros.
- Combinational path: wr_* to rd_* only when BYPASS=1; no other combinational input-to-output paths except rd_address to rd_*.

## Test plan
- Reset: fill r1..r31 with nonzero values, assert reset for 1 cycle with wr_en=2'b11 to r5 -> every register reads 0 and every rd_busy = 0; r5 is not written.
- Dual write collision: wr_en=2'b11, both to r7, port0=32'hAAAA_0000, port1=32'h5555_1111 -> next cycle r7 = 32'h5555_1111. With BYPASS=1, the same-cycle read of r7 also returns 32'h5555_1111.
- Bypass on/off: write r3=32'hDEAD_BEEF while port 0 reads r3 -> BYPASS=1 returns DEAD_BEEF the same cycle; BYPASS=0 returns the old value, then DEAD_BEEF next cycle.
- Scoreboard: reserve r9 -> rd_busy=1 the following cycles. Write r9=42 on port 1 -> busy clears (same cycle if BYPASS=1). Reserve r9 and write r9 in the same cycle -> busy stays 1 and data = new value.
- Zero register: write 32'hFFFF_FFFF to r0 and reserve r0 -> r0 reads 0 with rd_busy=0 on all ports, including the bypass cycle.
- Parametrisation: DATA_WIDTH=16, ADDR_WIDTH=3, READ_PORTS=4 -> write r1..r7 = index*0x111, then read all four ports at distinct addresses -> correct per-port packed data. Highest address r7 is writable, with no wrap to r0.
